// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants for the data memory unit.
// Holds op encodings, default base address, MMIO addresses and window mask.
package dmem_pkg;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    localparam logic [31:0] DMEM_BASE   = 32'h8000_0000;
    localparam logic [31:0] MMIO_PUTC   = 32'hA000_0000;
    localparam logic [31:0] MMIO_CYCLES = 32'hA000_0004;
    localparam logic [31:0] MMIO_MASK   = 32'hFFFF_FF00;

    typedef enum logic [1:0] {
        W_B,
        W_H,
        W_W
    } width_e;

    // Reserved encodings fall through to word width.
    function automatic width_e op_width(input logic [2:0] op);
        width_e w;
        case (op)
            OP_LB, OP_LBU: w = W_B;
            OP_LH, OP_LHU: w = W_H;
            default:       w = W_W;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/dmem_ext.sv
// dmem_ext: combinational lane select and sign/zero extension of a load word.
// Ports: word (RAM word), lane (addr[1:0]), op (func3) in; result out.
module dmem_ext
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  op,
    output logic [31:0] result
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b      = word[{lane, 3'b000} +: 8];
        h      = lane[1] ? word[31:16] : word[15:0];
        result = word;
        unique case (1'b1)
            (op == OP_LB):  result = {{24{b[7]}}, b};
            (op == OP_LBU): result = {24'h0, b};
            (op == OP_LH):  result = {{16{h[15]}}, h};
            (op == OP_LHU): result = {16'h0, h};
            default:        result = word;
        endcase
    end

endmodule

// File: rtl/dmem_unit.sv
// dmem_unit: byte-addressable data RAM, 1-cycle registered loads, sticky err.
// Ports: clk, rst (sync high), addr, datain, op, we in; dataout, err,
// putc_valid, putc_data, cycles out. `DMEM_MMIO_EN adds console and counter.
module dmem_unit
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE,
    parameter int          DEPTH_WORDS = 32768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    input  logic [2:0]  op,
    input  logic        we,
    output logic [31:0] dataout,
    output logic        err,
    output logic        putc_valid,
    output logic [7:0]  putc_data,
    output logic [31:0] cycles
);

    localparam int AW = $clog2(DEPTH_WORDS);

    width_e        wd;
    logic [31:0]   off;
    logic          in_ram;
    logic          misal;
    logic          ram_ok;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [3:0]    wen;
    logic          bad_store;
    logic          load_zero;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   rdata;
    logic [1:0]    lane_q;
    logic [2:0]    op_q;
    logic          zero_q;
    logic [31:0]   ext_out;

    assign wd     = op_width(op);
    assign off    = addr - BASE_ADDR;
    // 33-bit compare so the top of the window cannot wrap.
    assign in_ram = (addr >= BASE_ADDR)
                 && ({1'b0, off} < (33'(DEPTH_WORDS) << 2));
    assign misal  = ((wd == W_H) && addr[0])
                 || ((wd == W_W) && (addr[1:0] != 2'b00));
    assign ram_ok = in_ram && !misal;
    assign idx    = off[AW+1:2];

    always_comb begin
        be    = 4'b1111;
        wdata = datain;
        unique case (1'b1)
            (wd == W_B): begin
                be    = 4'b0001 << addr[1:0];
                wdata = {4{datain[7:0]}};
            end
            (wd == W_H): begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{datain[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = datain;
            end
        endcase
    end

    assign wen = {4{we && ram_ok && !rst}} & be;

    // Read-first RAM: the registered read sees the pre-write word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
        rdata <= mem[idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b1;
            lane_q <= 2'b00;
            op_q   <= OP_LW;
        end else begin
            zero_q <= load_zero;
            lane_q <= addr[1:0];
            op_q   <= op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                 err <= 1'b0;
        else if (we && bad_store) err <= 1'b1;
    end

    dmem_ext u_ext (
        .word   (rdata),
        .lane   (lane_q),
        .op     (op_q),
        .result (ext_out)
    );

`ifdef DMEM_MMIO_EN
    logic        mmio_hit;
    logic        cyc_hit;
    logic        cyc_sel_q;
    logic [31:0] cyc_q;
    logic [31:0] cyc_cnt;
    logic        putc_v;
    logic [7:0]  putc_d;

    assign mmio_hit  = (addr & MMIO_MASK) == (MMIO_PUTC & MMIO_MASK);
    assign cyc_hit   = (addr == MMIO_CYCLES) && (wd == W_W);
    assign bad_store = !mmio_hit && !ram_ok;
    assign load_zero = !ram_ok && !cyc_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt   <= 32'h0;
            putc_v    <= 1'b0;
            putc_d    <= 8'h0;
            cyc_sel_q <= 1'b0;
            cyc_q     <= 32'h0;
        end else begin
            cyc_cnt   <= cyc_cnt + 32'd1;
            putc_v    <= we && (addr == MMIO_PUTC);
            if (we && (addr == MMIO_PUTC)) putc_d <= datain[7:0];
            cyc_sel_q <= cyc_hit;
            cyc_q     <= cyc_cnt;
        end
    end

    assign dataout    = zero_q ? 32'h0 : (cyc_sel_q ? cyc_q : ext_out);
    assign putc_valid = putc_v;
    assign putc_data  = putc_d;
    assign cycles     = cyc_cnt;
`else
    assign bad_store  = !ram_ok;
    assign load_zero  = !ram_ok;
    assign dataout    = zero_q ? 32'h0 : ext_out;
    assign putc_valid = 1'b0;
    assign putc_data  = 8'h0;
    assign cycles     = 32'h0;
`endif

endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit: directed vector table, corner sequences and a random run
// checked against a byte-array reference model of dmem_unit.
module tb_dmem_unit;
    import dmem_pkg::*;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 32768;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] datain;
    logic [2:0]  op;
    logic        we;
    logic [31:0] dataout;
    logic        err;
    logic        putc_valid;
    logic [7:0]  putc_data;
    logic [31:0] cycles;

    always #5 clk = ~clk;

    dmem_unit #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .datain     (datain),
        .op         (op),
        .we         (we),
        .dataout    (dataout),
        .err        (err),
        .putc_valid (putc_valid),
        .putc_data  (putc_data),
        .cycles     (cycles)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [7:0]  mbytes [int unsigned];
    logic        m_err;
    logic [31:0] exp_d;
    logic [31:0] tb_cyc;

    always @(posedge clk) tb_cyc <= rst ? 32'h0 : tb_cyc + 32'd1;

    typedef struct {
        logic        w;
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        bit          chk_d;
    } vec_t;

    vec_t tv[$];

    function automatic int nbytes(input logic [2:0] o);
        if (o[1:0] == 2'b00) return 1;
        if (o[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit is_mmio(input logic [31:0] a);
`ifdef DMEM_MMIO_EN
        return a[31:8] == 24'hA00000;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit bad(input logic [31:0] a, input logic [2:0] o);
        longint la = longint'(a);
        longint lb = longint'(BASE);
        int     n  = nbytes(o);
        if ((la % n) != 0) return 1'b1;
        return !(la >= lb && la < lb + 4 * DEPTH);
    endfunction

    function automatic logic [31:0] mload(input logic [31:0] a,
                                          input logic [2:0] o);
        longint v = 0;
        int     n = nbytes(o);
        if (bad(a, o)) return 32'h0;
        for (int k = 0; k < n; k++) begin
            int unsigned ka = a + k;
            longint bv = mbytes.exists(ka) ? longint'(mbytes[ka]) : 0;
            v = v + (bv << (8 * k));
        end
        if ((o == OP_LB || o == OP_LH) && v >= (longint'(1) << (8*n - 1)))
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic w, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] d);
        we     = w;
        op     = o;
        addr   = a;
        datain = d;
        exp_d  = is_mmio(a) ? 32'h0 : mload(a, o);
        if (w && !is_mmio(a)) begin
            if (bad(a, o)) m_err = 1'b1;
            else
                for (int k = 0; k < nbytes(o); k++)
                    mbytes[a + k] = d[8*k +: 8];
        end
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        we  = 1'b1;
        op  = OP_LW;
        addr = BASE;
        datain = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        we  = 1'b0;
        chk({nm, "_dout"}, dataout, 32'h0);
        chk({nm, "_err"}, {31'h0, err}, 32'h0);
        chk({nm, "_putc"}, {23'h0, putc_valid, putc_data}, 32'h0);
        chk({nm, "_cyc"}, cycles, 32'h0);
        rst   = 1'b0;
        m_err = 1'b0;
    endtask

    initial begin
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] c1;
        rst = 1'b1; we = 1'b0; op = OP_LW; addr = BASE; datain = 32'h0;
        m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset");

        tv.push_back('{1'b1, OP_LW,  32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0});
        tv.push_back('{1'b0, OP_LB,  32'h8000_0013, 32'h0, 32'hFFFF_FFDE, 1'b1});
        tv.push_back('{1'b0, OP_LBU, 32'h8000_0013, 32'h0, 32'h0000_00DE, 1'b1});
        tv.push_back('{1'b0, OP_LH,  32'h8000_0010, 32'h0, 32'hFFFF_BEEF, 1'b1});
        tv.push_back('{1'b1, OP_LB,  32'h8000_0011, 32'h55, 32'hFFFF_FFBE, 1'b1});
        tv.push_back('{1'b0, OP_LW,  32'h8000_0010, 32'h0, 32'hDEAD_55EF, 1'b1});
        tv.push_back('{1'b0, OP_LHU, 32'h8000_0012, 32'h0, 32'h0000_DEAD, 1'b1});
        tv.push_back('{1'b0, OP_LH,  32'h8000_0012, 32'h0, 32'hFFFF_DEAD, 1'b1});
        tv.push_back('{1'b0, OP_LW,  32'h7FFF_FFFC, 32'h0, 32'h0, 1'b1});
        tv.push_back('{1'b0, OP_LW,  32'h8002_0000, 32'h0, 32'h0, 1'b1});
        tv.push_back('{1'b1, OP_LW,  32'h8001_FFFC, 32'h1234_5678, 32'h0, 1'b0});
        tv.push_back('{1'b0, OP_LW,  32'h8001_FFFC, 32'h0, 32'h1234_5678, 1'b1});
        tv.push_back('{1'b0, 3'b011, 32'h8000_0010, 32'h0, 32'hDEAD_55EF, 1'b1});
        tv.push_back('{1'b0, 3'b110, 32'h8000_0010, 32'h0, 32'hDEAD_55EF, 1'b1});
        tv.push_back('{1'b0, 3'b111, 32'h8000_0012, 32'h0, 32'h0, 1'b1});
        tv.push_back('{1'b0, OP_LH,  32'h8000_0011, 32'h0, 32'h0, 1'b1});
        tv.push_back('{1'b0, OP_LBU, 32'h8000_0011, 32'h0, 32'h0000_0055, 1'b1});
        tv.push_back('{1'b0, OP_LW,  32'h8000_0012, 32'h0, 32'h0, 1'b1});

        foreach (tv[i]) begin
            step(tv[i].w, tv[i].o, tv[i].a, tv[i].d);
            if (tv[i].chk_d)
                chk($sformatf("vec%0d", i), dataout, tv[i].exp);
            chk($sformatf("vec%0d_err", i), {31'h0, err}, 32'h0);
        end

        step(1'b1, OP_LW, 32'h8000_0020, 32'hA5A5_A5A5);
        step(1'b1, OP_LW, 32'h8000_0020, 32'h5A5A_5A5A);
        chk("rdfirst_old", dataout, 32'hA5A5_A5A5);
        step(1'b0, OP_LW, 32'h8000_0020, 32'h0);
        chk("rdfirst_new", dataout, 32'h5A5A_5A5A);

        step(1'b1, OP_LW, 32'h8000_0000, 32'h1122_3344);
        step(1'b1, OP_LH, 32'h8000_0001, 32'h0000_BEEF);
        chk("misal_dout", dataout, 32'h0);
        chk("misal_err", {31'h0, err}, 32'h1);
        step(1'b0, OP_LW, 32'h8000_0000, 32'h0);
        chk("misal_word", dataout, 32'h1122_3344);
        chk("misal_sticky", {31'h0, err}, 32'h1);
        do_reset("rst2");
        step(1'b0, OP_LW, 32'h8000_0000, 32'h0);
        chk("rst_keep", dataout, 32'h1122_3344);
        chk("rst_err", {31'h0, err}, 32'h0);
`ifdef DMEM_MMIO_EN
        chk("cyc_count", cycles, tb_cyc);
`else
        chk("cyc_tied", cycles, 32'h0);
`endif

`ifdef DMEM_MMIO_EN
        step(1'b1, OP_LB, MMIO_PUTC, 32'h41);
        chk("putc_v", {31'h0, putc_valid}, 32'h1);
        chk("putc_d", {24'h0, putc_data}, 32'h41);
        chk("putc_err", {31'h0, err}, 32'h0);
        step(1'b0, OP_LW, BASE, 32'h0);
        chk("putc_pulse", {31'h0, putc_valid}, 32'h0);
        step(1'b0, OP_LW, MMIO_CYCLES, 32'h0);
        v1 = dataout;
        c1 = tb_cyc - 32'd1;
        chk("cyc_sample", v1, c1);
        repeat (4) step(1'b0, OP_LW, BASE, 32'h0);
        step(1'b0, OP_LW, MMIO_CYCLES, 32'h0);
        v2 = dataout;
        chk("cyc_delta", v2 - v1, 32'd5);
        step(1'b1, OP_LW, 32'hA000_0008, 32'hFFFF_FFFF);
        chk("mmio_other", dataout, 32'h0);
        chk("mmio_noerr", {31'h0, err}, 32'h0);
        chk("mmio_noputc", {31'h0, putc_valid}, 32'h0);
`else
        step(1'b1, OP_LB, 32'hA000_0000, 32'h41);
        chk("nommio_err", {31'h0, err}, 32'h1);
        chk("nommio_putc", {31'h0, putc_valid}, 32'h0);
        v1 = 32'h0; v2 = 32'h0; c1 = 32'h0;
`endif

        do_reset("rst3");
        for (int w = 0; w < 64; w++)
            step(1'b1, OP_LW, BASE + 32'(4 * w), $urandom);
        for (int i = 0; i < 400; i++) begin
            int unsigned r = $urandom_range(0, 19);
            logic [31:0] a;
            if (r < 17)       a = BASE + 32'($urandom_range(0, 255));
            else if (r < 19)  a = BASE - 32'($urandom_range(1, 16));
            else              a = BASE + 32'(4 * DEPTH)
                                   + 32'($urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 a, $urandom);
            chk($sformatf("rnd%0d", i), dataout, exp_d);
            chk($sformatf("rnd%0d_err", i), {31'h0, err}, {31'h0, m_err});
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_unit.md
DMEM_UNIT -- requirements
Module: dmem_unit

Interface
REQ-001 The parameters SHALL be:
- BASE_ADDR, 32'h80000000, byte address of word 0.
- DEPTH_WORDS, 32768, number of 32-bit words.
REQ-002 The ports SHALL be:
- clk  in  1  sole clock; all state changes on posedge clk.
- rst  in  1  reset, synchronous and active-high.
- addr  in  32  byte address.
- datain  in  32  store data, right-aligned.
- op  in  3  access type, RISC-V func3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- we  in  1  store request this cycle.
- dataout  out  32  registered load result.
- err  out  1  sticky access-error flag.
- putc_valid  out  1  one-cycle console strobe.
- putc_data  out  8  console byte.
- cycles  out  32  free-running cycle counter.

Function
REQ-003 Every cycle with rst=0 SHALL be a load of (addr, op); dataout SHALL present the result one cycle later (latency 1), whether or not we is high.
REQ-004 Loads SHALL extract the addressed byte or halfword from the word at (addr-BASE_ADDR)>>2, then extend it:
- op 000/001: sign-extend.
- op 100/101: zero-extend.
- op 010: full word.
REQ-005 When we=1, the store SHALL update only the addressed lanes (byte: addr[1:0]; half: addr[1]; word: all four) at posedge clk.
REQ-006 A load and store to the same word in one cycle SHALL be read-first: dataout shows the pre-store contents.
REQ-007 An access is misaligned when op is h/hu with addr[0]=1, or w with addr[1:0]!=0. A misaligned store SHALL be suppressed, and the load SHALL return 32'h0.
REQ-008 An access is out of range when addr<BASE_ADDR or addr>=BASE_ADDR+4*DEPTH_WORDS and it is not an MMIO address (REQ-014). An out-of-range store SHALL be dropped, and the load SHALL return 32'h0.
REQ-009 err SHALL set on the posedge following any misaligned or out-of-range store, and SHALL stay set until rst.
REQ-010 err SHALL NOT set for a misaligned or out-of-range load. The CPU issues speculative loads every cycle.
REQ-011 op values 011, 110 and 111 SHALL be treated as word width and zero-extended.
REQ-012 cycles SHALL increment by 1 every posedge clk while rst=0, and SHALL wrap from 32'hFFFFFFFF to 0.

Reset
REQ-013 While rst=1:
- dataout, err, putc_valid, putc_data and cycles SHALL be 0 at the next posedge.
- Stores SHALL be ignored.
- Memory contents SHALL be preserved (no array clear).
- Behaviour SHALL resume on the first posedge with rst=0. A store coincident with rst asserting mid-operation is dropped.

Configuration
REQ-014 With DMEM_MMIO_EN defined:
- A store to 32'hA0000000 (any op) SHALL pulse putc_valid for exactly one cycle, with putc_data=datain[7:0] in the same cycle.
- A word load from 32'hA0000004 SHALL return cycles as sampled at the load's posedge.
- Other addresses in 32'hA0000000..32'hA00000FF SHALL read 0, and writes to them SHALL be ignored without setting err.
REQ-015 Without DMEM_MMIO_EN:
- putc_valid, putc_data and cycles SHALL be tied to 0, and the counter SHALL not be synthesised.
- 32'hA00000xx SHALL be handled as out of range (REQ-008).

Structure
REQ-016 Package dmem_pkg SHALL hold:
- the op encoding constants;
- BASE_ADDR default;
- the MMIO_PUTC and MMIO_CYCLES addresses;
- the MMIO window mask.
REQ-017 Lane extraction/extension SHALL be a sub-module, dmem_ext, which is combinational: word, addr[1:0] and op in; 32-bit result out.
REQ-018 Storage SHALL be a single inferred synchronous-read RAM with per-byte write enables.

Verification
REQ-019 The bench SHALL cover these scenarios:
- sw 32'h80000010 <- 32'hDEADBEEF, then lb at 0x80000013 -> 32'hFFFFFFDE; lbu -> 32'h000000DE; lh at 0x80000010 -> 32'hFFFFBEEF.
- sb 0x80000011 <- 32'h55, then lw 0x80000010 -> 32'hDEAD55EF.
- Simultaneous store and load to the same word (REQ-006): the cycle after the store shows old data; the next load shows new data.
- sh to 0x80000001 -> word unchanged, err=1 next cycle; a later rst=1 -> err=0 and the word is still unchanged.
- lw at 0x7FFFFFFC -> dataout=0, err stays 0.
- DMEM_MMIO_EN: sb 0xA0000000 <- 32'h41 -> putc_valid=1 for one cycle with putc_data=8'h41; two lw from 0xA0000004, 5 cycles apart, differ by 5. Without DMEM_MMIO_EN, the same store sets err.
